// File: rtl/intr_cond_pkg.sv
// Helpers shared by the interrupt conditioner: ceiling log2 and the
// synchronizer-depth legality check built on it.
package intr_cond_pkg;

  localparam int SYNC_LOG_MIN = 1;
  localparam int SYNC_LOG_MAX = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Depths 2..4 map to clog2 values 1..2; 1 and anything above 4 fall outside.
  function automatic bit sync_stages_ok(input int stages);
    return (clog2(stages) >= SYNC_LOG_MIN) && (clog2(stages) <= SYNC_LOG_MAX);
  endfunction

endpackage

// File: rtl/intr_cond_chan.sv
// One interrupt channel: event synchronizer, polarity/edge qualification,
// pending and sticky overflow flags, and the holdoff-limited request pulse.
module intr_chan
  import intr_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              evt_i,
  input  logic              en_i,
  input  logic              edge_i,
  input  logic              pol_i,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic              clr_i,
  output logic              intr_req_o,
  output logic              pend_o,
  output logic              ovf_o
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   act_d_r;
  logic                   pend_r;
  logic                   ovf_r;
  logic                   req_r;
  logic [HOLD_W-1:0]      hold_cnt_r;

  logic                   act_s;
  logic                   det_s;
  logic                   hold_zero_s;
  logic                   issue_s;
  logic                   pend_nxt_s;
  logic                   ovf_nxt_s;
  logic [HOLD_W-1:0]      hold_nxt_s;

  // The synchronizer and the previous active level are deliberately untouched by clr_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_r  <= {SYNC_STAGES{1'b0}};
      act_d_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], evt_i};
      act_d_r <= act_s;
    end
  end

  always_comb begin
    act_s       = sync_r[SYNC_STAGES-1] ^ pol_i;
    hold_zero_s = (hold_cnt_r == {HOLD_W{1'b0}});
    if (edge_i) begin
      det_s = en_i & act_s & ~act_d_r;
    end else begin
      det_s = en_i & act_s;
    end
    issue_s = pend_r & en_i & hold_zero_s & ~clr_i;
  end

  // Clear dominates; a detect in the issue cycle keeps the flag pending.
  always_comb begin
    pend_nxt_s = pend_r;
    ovf_nxt_s  = ovf_r;
    hold_nxt_s = hold_cnt_r;
    if (clr_i) begin
      pend_nxt_s = 1'b0;
      ovf_nxt_s  = 1'b0;
      hold_nxt_s = {HOLD_W{1'b0}};
    end else begin
      if (det_s && edge_i && pend_r) begin
        ovf_nxt_s = 1'b1;
      end else begin
        ovf_nxt_s = ovf_r;
      end
      if (det_s) begin
        pend_nxt_s = 1'b1;
      end else if (issue_s) begin
        pend_nxt_s = 1'b0;
      end else begin
        pend_nxt_s = pend_r;
      end
      if (issue_s) begin
        hold_nxt_s = hold_i;
      end else if (!hold_zero_s) begin
        hold_nxt_s = hold_cnt_r - {{(HOLD_W-1){1'b0}}, 1'b1};
      end else begin
        hold_nxt_s = hold_cnt_r;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_r     <= 1'b0;
      ovf_r      <= 1'b0;
      req_r      <= 1'b0;
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else begin
      pend_r     <= pend_nxt_s;
      ovf_r      <= ovf_nxt_s;
      req_r      <= issue_s;
      hold_cnt_r <= hold_nxt_s;
    end
  end

  assign intr_req_o = req_r;
  assign pend_o     = pend_r;
  assign ovf_o      = ovf_r;

endmodule

// File: rtl/intr_cond.sv
// Per-thread interrupt conditioner feeding the core's request vector:
// THREADS independent channels sharing one holdoff value.
module intr_cond
  import intr_cond_pkg::*;
#(
  parameter int THREADS     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_W      = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [THREADS-1:0] evt_i,
  input  logic [THREADS-1:0] en_i,
  input  logic [THREADS-1:0] edge_i,
  input  logic [THREADS-1:0] pol_i,
  input  logic [HOLD_W-1:0]  hold_i,
  input  logic [THREADS-1:0] clr_i,
  output logic [THREADS-1:0] intr_req_o,
  output logic [THREADS-1:0] pend_o,
  output logic [THREADS-1:0] ovf_o
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
    $error("intr_cond: SYNC_STAGES must be within 2..4");
  end

  for (genvar n = 0; n < THREADS; n++) begin : g_chan
    intr_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .HOLD_W     (HOLD_W)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .evt_i     (evt_i[n]),
      .en_i      (en_i[n]),
      .edge_i    (edge_i[n]),
      .pol_i     (pol_i[n]),
      .hold_i    (hold_i),
      .clr_i     (clr_i[n]),
      .intr_req_o(intr_req_o[n]),
      .pend_o    (pend_o[n]),
      .ovf_o     (ovf_o[n])
    );
  end

endmodule

// File: tb/tb_intr_cond.sv
// Self-checking bench for intr_cond: cycle-level behavioural model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_intr_cond;

  localparam int THREADS     = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_W      = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] evt   = 8'h00;
  logic [7:0] en    = 8'h00;
  logic [7:0] edg   = 8'h00;
  logic [7:0] pol   = 8'h00;
  logic [7:0] clr   = 8'h00;
  logic [7:0] hold  = 8'h00;
  logic [7:0] req;
  logic [7:0] pend;
  logic [7:0] ovf;

  always #5 clk = ~clk;

  intr_cond #(
    .THREADS    (THREADS),
    .SYNC_STAGES(SYNC_STAGES),
    .HOLD_W     (HOLD_W)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .evt_i     (evt),
    .en_i      (en),
    .edge_i    (edg),
    .pol_i     (pol),
    .hold_i    (hold),
    .clr_i     (clr),
    .intr_req_o(req),
    .pend_o    (pend),
    .ovf_o     (ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: per-channel flags plus "earliest cycle a pulse may issue" instead of a counter.
  logic [7:0] m_req      = 8'h00;
  logic [7:0] m_pend     = 8'h00;
  logic [7:0] m_ovf      = 8'h00;
  logic [7:0] m_prev_act = 8'h00;
  int         m_next_ok[8];
  int         cyc = 0;
  logic [7:0] evt_log[$];

  task automatic model_reset();
    m_req = 8'h00;
    m_pend = 8'h00;
    m_ovf = 8'h00;
    m_prev_act = 8'h00;
    evt_log.delete();
    for (int i = 0; i < 8; i++) m_next_ok[i] = 0;
  endtask

  task automatic model_step();
    logic [7:0] s;
    logic [7:0] act;
    logic [7:0] det;
    logic [7:0] issue;
    s = 8'h00;
    if (evt_log.size() >= SYNC_STAGES) s = evt_log[evt_log.size() - SYNC_STAGES];
    act = s ^ pol;
    for (int i = 0; i < 8; i++) begin
      det[i]   = en[i] && (edg[i] ? (act[i] && !m_prev_act[i]) : act[i]);
      issue[i] = m_pend[i] && en[i] && (cyc >= m_next_ok[i]) && !clr[i];
      if (clr[i]) begin
        m_pend[i] = 1'b0;
        m_ovf[i] = 1'b0;
        m_next_ok[i] = 0;
      end else begin
        if (det[i] && edg[i] && m_pend[i]) m_ovf[i] = 1'b1;
        if (issue[i]) m_next_ok[i] = cyc + int'(hold) + 1;
        m_pend[i] = det[i] || (m_pend[i] && !issue[i]);
      end
    end
    m_req = issue;
    m_prev_act = act;
    evt_log.push_back(evt);
    if (evt_log.size() > 8) void'(evt_log.pop_front());
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("req_vs_model", 32'(req), 32'(m_req));
      check("pend_vs_model", 32'(pend), 32'(m_pend));
      check("ovf_vs_model", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic settle();
    evt = 8'h00;
    en  = 8'h00;
    clr = 8'h00;
    repeat (4) @(negedge clk);
    clr = 8'hFF;
    @(negedge clk);
    clr = 8'h00;
  endtask

  initial begin
    logic [15:0] req_h;
    logic [15:0] pend_h;
    logic [7:0]  other;
    int first;
    int last;
    int second;
    int npulse;
    int bad_gap;
    int full_at;
    logic [7:0] seen_a;
    logic [7:0] seen_b;

    repeat (3) @(negedge clk);
    check("reset_req", 32'(req), 32'h0);
    check("reset_pend", 32'(pend), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Edge latency on channel 3
    edg = 8'h08; en = 8'h08; pol = 8'h00; hold = 8'd5;
    @(negedge clk);
    evt[3] = 1'b1;
    req_h = 16'h0; pend_h = 16'h0; other = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_h[k] = req[3];
      pend_h[k] = pend[3];
      other = other | ((req | pend | ovf) & 8'hF7);
    end
    check("t1_req_timing", 32'(req_h), 32'h0008);
    check("t1_pend_timing", 32'(pend_h), 32'h0004);
    check("t1_other_bits", 32'(other), 32'h0);

    // Level repeat on channel 0
    settle();
    edg = 8'h00; en = 8'h01; hold = 8'd3;
    @(negedge clk);
    evt[0] = 1'b1;
    first = -1; last = -1; npulse = 0; bad_gap = 0; seen_a = 8'h00;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req[0]) begin
        if (first < 0) first = k;
        if (last >= 0 && (k - last) != 4) bad_gap++;
        last = k;
        npulse++;
      end
      seen_a = seen_a | ovf;
      if (k == 19) evt[0] = 1'b0;
    end
    check("t2_first_pulse", 32'(first), 32'd3);
    check("t2_pulse_count", 32'(npulse), 32'd6);
    check("t2_bad_gaps", 32'(bad_gap), 32'd0);
    check("t2_ovf", 32'(seen_a), 32'h0);

    // Overflow on channel 1 while a long holdoff keeps the flag pending
    settle();
    edg = 8'h02; en = 8'h02; hold = 8'd40;
    @(negedge clk);
    evt[1] = 1'b1;
    npulse = 0; second = -1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (req[1]) begin
        npulse++;
        if (npulse == 2) second = k;
      end
      if (k == 4) evt[1] = 1'b0;
      if (k == 9) evt[1] = 1'b1;
      if (k == 14) evt[1] = 1'b0;
      if (k == 19) evt[1] = 1'b1;
      if (k == 25) begin
        check("t3_pend_held", 32'(pend[1]), 32'd1);
        check("t3_ovf_set", 32'(ovf[1]), 32'd1);
      end
    end
    check("t3_pulse_count", 32'(npulse), 32'd2);
    check("t3_second_pulse", 32'(second), 32'd44);
    check("t3_ovf_sticky", 32'(ovf[1]), 32'd1);
    clr = 8'h02;
    @(negedge clk);
    clr = 8'h00;
    check("t3_ovf_cleared", 32'(ovf[1]), 32'd0);
    en = 8'h00;
    evt[1] = 1'b0;
    repeat (3) @(negedge clk);
    evt[1] = 1'b1;
    seen_a = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen_a = seen_a | pend | req;
    end
    check("t3_masked", 32'(seen_a), 32'h0);

    // Clear racing a set on channel 2
    settle();
    edg = 8'h04; en = 8'h04; hold = 8'd0;
    @(negedge clk);
    evt[2] = 1'b1;
    seen_a = 8'h00; seen_b = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen_a = seen_a | pend;
      seen_b = seen_b | req;
      if (k == 1) clr = 8'h04;
      if (k == 2) clr = 8'h00;
    end
    check("t4_pend_blocked", 32'(seen_a), 32'h0);
    check("t4_req_blocked", 32'(seen_b), 32'h0);

    // All channels active-low, falling together
    settle();
    pol = 8'hFF; edg = 8'hFF; hold = 8'd0; evt = 8'hFF; en = 8'hFF;
    repeat (4) @(negedge clk);
    clr = 8'hFF;
    @(negedge clk);
    clr = 8'h00;
    repeat (2) @(negedge clk);
    evt = 8'h00;
    full_at = -1; npulse = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req == 8'hFF && full_at < 0) full_at = k;
      if (req != 8'h00) npulse++;
    end
    check("t5_all_at", 32'(full_at), 32'd3);
    check("t5_single_cycle", 32'(npulse), 32'd1);

    // Reset in the middle of a long holdoff, level mode
    settle();
    pol = 8'h00; edg = 8'h00; en = 8'h01; hold = 8'd200;
    @(negedge clk);
    evt[0] = 1'b1;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req[0] && first < 0) first = k;
    end
    check("t6_first_pulse", 32'(first), 32'd3);
    check("t6_pend_before", 32'(pend[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(req), 32'h0);
    check("t6_rst_pend", 32'(pend), 32'h0);
    check("t6_rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req[0] && first < 0) first = k;
    end
    check("t6_after_reset", 32'(first), 32'd3);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      evt = evt ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 63) == 0) begin
        en   = 8'($urandom) | 8'($urandom);
        edg  = 8'($urandom);
        pol  = 8'($urandom);
        hold = 8'($urandom_range(0, 6));
      end
      clr = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    clr = 8'h00;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
